ahb_mem_slave: RTL and testbench

Parametrised AHB-Lite memory slave: generalises the single-width, zero-wait test slave to configurable data/address width and depth, programmable wait states, byte-lane writes via `hsize`, SEQ/BUSY transfer types and an optional ERROR response for out-of-range or oversize accesses. It sits behind the AHB decoder as a bus-attached scratch/backing memory and is the standard target for master-side smoke tests.

---
 rtl/ahb_mem_slave.sv | 123 ++++++++++++
 tb/tb_ahb_mem_slave.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: configurable width/depth, programmable wait states, byte-lane writes.
// Optional ERROR response for out-of-range / oversize accesses: define AHB_MEM_SLAVE_ERRRESP_EN.
module ahb_mem_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic              hready,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp
);
  localparam int NB       = DATA_W / 8;
  localparam int LB       = $clog2(NB);
  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int memDepth = DEPTH;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [DATA_W-1:0] mem [memDepth];

  logic [2:0]        state;
  logic [3:0]        cnt;
  logic              wr_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rst_q;
  logic              accept;
  logic              err_req;
  logic [NB-1:0]     lane_en;
  logic [IDX_W-1:0]  idx;

  assign accept = hsel & hready & htrans[1];

`ifdef AHB_MEM_SLAVE_ERRRESP_EN
  logic [ADDR_W:0] widx_in;
  assign widx_in = {1'b0, haddr} >> LB;
  assign err_req = (widx_in >= (ADDR_W+1)'(DEPTH)) || (int'(hsize) > LB);
  assign hresp   = (state == S_ERR1) || (state == S_ERR2);
`else
  assign err_req = 1'b0;
  assign hresp   = 1'b0;
`endif

  // Out-of-range indices wrap; with error responses enabled they never reach here.
  assign idx = IDX_W'(({1'b0, addr_q} >> LB) % (ADDR_W+1)'(DEPTH));

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      wr_q   <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      rst_q  <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      case (state)
        S_WAIT: begin
          if (cnt <= 4'd1) state <= S_DATA;
          else             cnt   <= cnt - 4'd1;
        end
        S_ERR1: state <= S_ERR2;
        default: begin
          // IDLE, DATA and ERR2 all complete this cycle, so a new address phase may start.
          if (accept) begin
            wr_q   <= hwrite;
            size_q <= hsize;
            addr_q <= haddr;
            if (err_req)               state <= S_ERR1;
            else if (WAIT_STATES == 0) state <= S_DATA;
            else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_STATES);
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Lanes: 2^size bytes in the aligned-down group; oversize means the whole word.
  always_comb begin
    int nbytes;
    int off;
    lane_en = '0;
    nbytes  = 1 << size_q;
    off     = int'(addr_q[LB-1:0]);
    if (int'(size_q) >= LB) begin
      lane_en = '1;
    end else begin
      off = off & ~(nbytes - 1);
      for (int b = 0; b < NB; b++)
        lane_en[b] = (b >= off) && (b < off + nbytes);
    end
  end

  always_ff @(posedge hclk) begin
    if (!hreset && state == S_DATA && wr_q) begin
      for (int b = 0; b < NB; b++)
        if (lane_en[b]) mem[idx][b*8 +: 8] <= hwdata[b*8 +: 8];
    end
  end

  assign hreadyout = !rst_q && (state != S_WAIT) && (state != S_ERR1);
  assign hrdata    = (state == S_DATA && !wr_q) ? mem[idx] : '0;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed + randomized bench for ahb_mem_slave: one zero-wait and one two-wait-state instance.
module tb_ahb_mem_slave;
  logic        clk = 1'b0;
  logic        hreset;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [15:0] haddr;
  logic [31:0] hwdata;
  logic        hsel0, hsel2;
  logic [31:0] hrdata0, hrdata2;
  logic        hro0, hro2, hresp0, hresp2;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mb [0:1023];

  always #5 clk = ~clk;

  ahb_mem_slave #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(0)) dut0 (
    .hclk(clk), .hreset(hreset), .hsel(hsel0), .hready(hro0), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .haddr(haddr), .hwdata(hwdata),
    .hrdata(hrdata0), .hreadyout(hro0), .hresp(hresp0));

  ahb_mem_slave #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(2)) dut2 (
    .hclk(clk), .hreset(hreset), .hsel(hsel2), .hready(hro2), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .haddr(haddr), .hwdata(hwdata),
    .hrdata(hrdata2), .hreadyout(hro2), .hresp(hresp2));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Single non-pipelined transfer; reports first-cycle resp, final resp/rdata and wait count.
  task automatic xfer(input bit d2, input bit wr, input logic [2:0] sz, input logic [15:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic resp1,
                      output logic resp, output int waits);
    hsel0 = !d2; hsel2 = d2; htrans = 2'd2; hwrite = wr; hsize = sz; haddr = a;
    step();
    htrans = 2'd0; hsel0 = 1'b0; hsel2 = 1'b0; hwdata = wd;
    waits = 0;
    resp1 = d2 ? hresp2 : hresp0;
    while ((d2 ? hro2 : hro0) !== 1'b1 && waits < 40) begin
      chk("rdata_in_wait", d2 ? hrdata2 : hrdata0, 32'h0);
      waits++;
      step();
    end
    if (waits >= 40) chk("ready_timeout", 32'(waits), 32'd0);
    rd   = d2 ? hrdata2 : hrdata0;
    resp = d2 ? hresp2 : hresp0;
    step();
  endtask

  function automatic logic [31:0] model_word(input logic [15:0] a);
    int w;
    w = (int'(a) >> 2) % 256;
    return {mb[w*4+3], mb[w*4+2], mb[w*4+1], mb[w*4]};
  endfunction

  task automatic model_write(input logic [2:0] sz, input logic [15:0] a, input logic [31:0] wd);
    int n, base, byte_a;
    n    = (sz > 3'd2) ? 4 : (1 << sz);
    base = int'(a) & ~(n - 1);
    for (int k = 0; k < n; k++) begin
      byte_a = (base + k) % 1024;
      mb[byte_a] = wd[(byte_a % 4)*8 +: 8];
    end
  endtask

  initial begin
    logic [31:0] rd, wd, exp;
    logic        r1, rr, wr, err;
    logic [2:0]  sz;
    logic [15:0] a;
    int          waits;

    hreset = 1'b1; htrans = 2'd0; hwrite = 1'b0; hsize = 3'd0; haddr = '0; hwdata = '0;
    hsel0 = 1'b0; hsel2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_ready0", 32'(hro0), 32'd0);
      chk("rst_ready2", 32'(hro2), 32'd0);
    end
    chk("rst_resp0", 32'(hresp0), 32'd0);
    chk("rst_rdata0", hrdata0, 32'h0);
    hreset = 1'b0;
    step();
    chk("post_rst_ready0", 32'(hro0), 32'd1);
    chk("post_rst_ready2", 32'(hro2), 32'd1);

    // Back-to-back pipelined writes at zero wait states
    hsel0 = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 16'h99 << 2;
    step();
    hwdata = 32'hfff; haddr = 16'h98 << 2;
    step();
    chk("b2b_mem99", dut0.mem[8'h99], 32'hfff);
    chk("b2b_ready1", 32'(hro0), 32'd1);
    hwdata = 32'hffe; haddr = 16'h97 << 2;
    step();
    chk("b2b_mem98", dut0.mem[8'h98], 32'hffe);
    chk("b2b_ready2", 32'(hro0), 32'd1);
    hwdata = 32'hffd; htrans = 2'd0; hsel0 = 1'b0;
    step();
    chk("b2b_mem97", dut0.mem[8'h97], 32'hffd);

    // Two wait states on a read
    xfer(1, 1, 3'd2, 16'h1d << 2, 32'h5a5a5a5a, rd, r1, rr, waits);
    chk("ws2_write_waits", 32'(waits), 32'd2);
    chk("ws2_rdata_before", hrdata2, 32'h0);
    xfer(1, 0, 3'd2, 16'h1d << 2, 32'h0, rd, r1, rr, waits);
    chk("ws2_read_waits", 32'(waits), 32'd2);
    chk("ws2_read_data", rd, 32'h5a5a5a5a);
    chk("ws2_read_resp", 32'(rr), 32'd0);
    chk("ws2_rdata_after", hrdata2, 32'h0);

    // Byte-lane write, then write+read back-to-back on the same word
    xfer(0, 1, 3'd2, 16'h10, 32'hffffffff, rd, r1, rr, waits);
    xfer(0, 1, 3'd0, 16'h12, 32'h00ab0000, rd, r1, rr, waits);
    chk("byte_write", dut0.mem[4], 32'hffabffff);
    hsel0 = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd0; haddr = 16'h10;
    step();
    hwdata = 32'h00000011; hwrite = 1'b0; hsize = 3'd2;
    step();
    chk("raw_read", hrdata0, 32'hffabff11);
    htrans = 2'd0; hsel0 = 1'b0;
    step();
    chk("raw_rdata_after", hrdata0, 32'h0);

    // Out-of-range access
    xfer(0, 1, 3'd2, 16'h0, 32'hc0ffee00, rd, r1, rr, waits);
    xfer(0, 0, 3'd2, 16'h400, 32'h0, rd, r1, rr, waits);
`ifdef AHB_MEM_SLAVE_ERRRESP_EN
    chk("oor_waits", 32'(waits), 32'd1);
    chk("oor_resp1", 32'(r1), 32'd1);
    chk("oor_resp2", 32'(rr), 32'd1);
    chk("oor_rdata", rd, 32'h0);
`else
    chk("oor_waits", 32'(waits), 32'd0);
    chk("oor_resp", 32'(rr), 32'd0);
    chk("oor_wrap_data", rd, 32'hc0ffee00);
`endif

    // Reset during the wait of a write
    hsel2 = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 16'h1d << 2;
    step();
    htrans = 2'd0; hsel2 = 1'b0; hwdata = 32'h12345678; hreset = 1'b1;
    step();
    chk("midrst_ready_a", 32'(hro2), 32'd0);
    step();
    chk("midrst_ready_b", 32'(hro2), 32'd0);
    hreset = 1'b0;
    step();
    chk("midrst_ready_after", 32'(hro2), 32'd1);
    chk("midrst_mem", dut2.mem[8'h1d], 32'h5a5a5a5a);

    // Randomized traffic against a byte-addressed reference model
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      xfer(0, 1, 3'd2, 16'(w * 4), wd, rd, r1, rr, waits);
      model_write(3'd2, 16'(w * 4), wd);
    end
    for (int i = 0; i < 200; i++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? 16'(16'h400 + $urandom_range(0, 63))
                                       : 16'($urandom_range(0, 63));
      wd = $urandom;
`ifdef AHB_MEM_SLAVE_ERRRESP_EN
      err = ((a >> 2) >= 16'd256) || (sz > 3'd2);
`else
      err = 1'b0;
`endif
      exp = model_word(a);
      xfer(0, wr, sz, a, wd, rd, r1, rr, waits);
      chk("rand_resp", 32'(rr), 32'(err));
      if (!wr) chk("rand_rdata", rd, err ? 32'h0 : exp);
      else if (!err) model_write(sz, a, wd);
    end
    for (int w = 0; w < 16; w++) begin
      xfer(0, 0, 3'd2, 16'(w * 4), 32'h0, rd, r1, rr, waits);
      chk("rand_final", rd, model_word(16'(w * 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
